// File: rtl/onchip_memory2_arbiter.sv
// onchip_memory2_arbiter: two-master arbiter and burst sequencer for the
// 32K x 32 single-port on-chip RAM. Port 0 is the acquisition DMA writer and
// port 1 is the host/CPU.
// Optional feature macro: OCM_ARB_ROUND_ROBIN_EN. When it is defined, IDLE ties
// alternate between the ports. When it is undefined, port 0 wins every tie.
module onchip_memory2_arbiter #(
  parameter int BURST_MAX = 8,
  parameter int BCW       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [14:0]    m0_address,
  input  logic [3:0]     m0_byteenable,
  input  logic           m0_read,
  input  logic           m0_write,
  input  logic [31:0]    m0_writedata,
  input  logic [BCW-1:0] m0_burstcount,
  output logic           m0_waitrequest,
  output logic [31:0]    m0_readdata,
  output logic           m0_readdatavalid,
  input  logic [14:0]    m1_address,
  input  logic [3:0]     m1_byteenable,
  input  logic           m1_read,
  input  logic           m1_write,
  input  logic [31:0]    m1_writedata,
  input  logic [BCW-1:0] m1_burstcount,
  output logic           m1_waitrequest,
  output logic [31:0]    m1_readdata,
  output logic           m1_readdatavalid,
  output logic [14:0]    mem_address,
  output logic [3:0]     mem_byteenable,
  output logic           mem_chipselect,
  output logic           mem_write,
  output logic [31:0]    mem_writedata,
  output logic           mem_clken,
  input  logic [31:0]    mem_readdata
);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

  state_t         state;
  logic           owner;
  logic           last_owner;
  logic [14:0]    addr_cnt;
  logic [BCW-1:0] beats_left;
  logic [3:0]     be_lat;
  logic           rv_valid;
  logic           rv_tag;

  logic           req0, req1, any_req, tie_pick, winner, sel;
  logic           s_read, s_write;
  logic [14:0]    s_addr;
  logic [3:0]     s_be;
  logic [31:0]    s_wdata;
  logic [BCW-1:0] s_bc, bc_nz, eff_len;
  logic           cs, we, accept;
  logic [14:0]    addr;
  logic [3:0]     be;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign any_req = req0 | req1;

`ifdef OCM_ARB_ROUND_ROBIN_EN
  // A tie goes to whichever port did not own the previous burst.
  assign tie_pick = ~last_owner;
`else
  // Fixed priority: DMA wins every tie. last_owner is tracked but not consulted.
  logic unused_last_owner;
  assign tie_pick          = 1'b0;
  assign unused_last_owner = last_owner;
`endif

  assign winner = (req0 & req1) ? tie_pick : req1;
  // In IDLE the port being granted drives the RAM. Otherwise the burst owner does.
  assign sel    = (state == IDLE) ? winner : owner;

  assign s_read  = sel ? m1_read       : m0_read;
  assign s_write = sel ? m1_write      : m0_write;
  assign s_addr  = sel ? m1_address    : m0_address;
  assign s_be    = sel ? m1_byteenable : m0_byteenable;
  assign s_wdata = sel ? m1_writedata  : m0_writedata;
  assign s_bc    = sel ? m1_burstcount : m0_burstcount;

  // Effective burst length: a burstcount of 0 counts as 1, and longer requests
  // are clamped to BURST_MAX.
  assign bc_nz   = (s_bc == '0) ? BCW'(1) : s_bc;
  assign eff_len = (bc_nz > BCW'(BURST_MAX)) ? BCW'(BURST_MAX) : bc_nz;

  // RAM strobe generation. Reset forces the port quiet during the reset cycle.
  always_comb begin
    cs     = 1'b0;
    we     = 1'b0;
    accept = 1'b0;
    addr   = addr_cnt;
    be     = be_lat;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cs     = 1'b1;
            we     = s_write & ~s_read;
            addr   = s_addr;
            be     = s_be;
            accept = 1'b1;
          end
        end
        RBURST: cs = 1'b1;
        WBURST: begin
          if (s_write) begin
            cs     = 1'b1;
            we     = 1'b1;
            be     = s_be;
            accept = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_address      = addr;
  assign mem_byteenable   = be;
  assign mem_chipselect   = cs;
  assign mem_write        = we;
  assign mem_writedata    = s_wdata;
  assign mem_clken        = 1'b1;

  assign m0_waitrequest   = ~(accept & ~sel);
  assign m1_waitrequest   = ~(accept & sel);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rv_valid & ~rv_tag & ~reset;
  assign m1_readdatavalid = rv_valid & rv_tag & ~reset;

  // Arbitration/burst state machine and the one-stage read-return tag pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b1;
      last_owner <= 1'b1;
      addr_cnt   <= '0;
      beats_left <= '0;
      be_lat     <= '0;
      rv_valid   <= 1'b0;
      rv_tag     <= 1'b0;
    end else begin
      rv_valid <= cs & ~we;
      rv_tag   <= sel;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_owner <= winner;
            addr_cnt   <= s_addr + 15'd1;
            be_lat     <= s_be;
            if (eff_len > BCW'(1)) begin
              beats_left <= eff_len - BCW'(1);
              state      <= s_read ? RBURST : WBURST;
            end
          end
        end
        RBURST: begin
          addr_cnt   <= addr_cnt + 15'd1;
          beats_left <= beats_left - BCW'(1);
          if (beats_left == BCW'(1)) state <= IDLE;
        end
        WBURST: begin
          if (s_write) begin
            addr_cnt   <= addr_cnt + 15'd1;
            beats_left <= beats_left - BCW'(1);
            if (beats_left == BCW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_memory2_arbiter.sv
// Testbench for onchip_memory2_arbiter. It runs a table of single-beat
// arbitration vectors first, then hand-written sequences for bursts, stalls,
// burstcount clamping, reset mid-burst and tie handling. Expected values
// follow OCM_ARB_ROUND_ROBIN_EN when the macro is defined.
module tb_onchip_memory2_arbiter;

`ifdef OCM_ARB_ROUND_ROBIN_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_burstcount, m1_burstcount;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  onchip_memory2_arbiter #(.BURST_MAX(8), .BCW(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM stand-in: byte-lane writes, read data registered one cycle after the address.
  logic [31:0] ram [0:32767] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0; m0_burstcount = 4'd1;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0; m1_burstcount = 4'd1;
  endtask

  task automatic set_req(input int p, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] be, input logic [31:0] d, input logic [31:0] bc);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = 15'(a); m0_byteenable = 4'(be);
      m0_writedata = d; m0_burstcount = 4'(bc);
    end else begin
      m1_read = rd; m1_write = wr; m1_address = 15'(a); m1_byteenable = 4'(be);
      m1_writedata = d; m1_burstcount = 4'(bc);
    end
  endtask

  function automatic logic [31:0] wait_of(input int p);
    return (p == 0) ? 32'(m0_waitrequest) : 32'(m1_waitrequest);
  endfunction

  function automatic logic [31:0] rv_of(input int p);
    return (p == 0) ? 32'(m0_readdatavalid) : 32'(m1_readdatavalid);
  endfunction

  function automatic logic [31:0] rd_of(input int p);
    return (p == 0) ? m0_readdata : m1_readdata;
  endfunction

  task automatic write_burst(input int p, input logic [31:0] a, input int n,
                             input logic [31:0] d, input logic [31:0] be);
    for (int i = 0; i < n; i++) begin
      tick;
      set_req(p, 0, 1, a, be, d, n);
      @(negedge clk);
      chk("wburst_wait", wait_of(p), 0);
      chk("wburst_we", 32'(mem_chipselect & mem_write), 1);
    end
    tick;
    clr;
    $display("write burst port %0d addr 0x%04h len %0d data 0x%08h be 0x%0h", p, a, n, d, be);
  endtask

  task automatic read_burst(input int p, input logic [31:0] a, input int n, input logic [31:0] exp);
    tick;
    set_req(p, 1, 0, a, 'hF, 0, n);
    @(negedge clk);
    chk("rburst_accept", wait_of(p), 0);
    for (int i = 0; i < n; i++) begin
      tick;
      clr;
      @(negedge clk);
      chk("rburst_rv", rv_of(p), 1);
      chk("rburst_data", rd_of(p), exp);
    end
    $display("read burst port %0d addr 0x%04h len %0d expect 0x%08h", p, a, n, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] r0, w0, r1, w1, a0, a1, be0, be1, d0, d1, bc0, bc1;
    logic [31:0] e_cs, e_we, e_addr, e_be, e_wd, e_w0, e_w1, e_rv0, e_rv1, e_rd;
  } vec_t;

  function automatic vec_t mkv(
      input string n,
      input logic [31:0] r0, w0, r1, w1, a0, a1, be0, be1, d0, d1, bc0, bc1,
      input logic [31:0] cs, we, ea, ebe, ewd, ew0, ew1, erv0, erv1, erd);
    vec_t v;
    v.name = n;
    v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.a0 = a0; v.a1 = a1;
    v.be0 = be0; v.be1 = be1; v.d0 = d0; v.d1 = d1; v.bc0 = bc0; v.bc1 = bc1;
    v.e_cs = cs; v.e_we = we; v.e_addr = ea; v.e_be = ebe; v.e_wd = ewd;
    v.e_w0 = ew0; v.e_w1 = ew1; v.e_rv0 = erv0; v.e_rv1 = erv1; v.e_rd = erd;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    int cnt_cs, cnt_rv, g, prev_g;
    logic [31:0] a_exp [5];
    logic [31:0] r_exp [3];

    // Each vector is a single beat held for one cycle. The readdatavalid and
    // readdata expectations refer to the read issued by the previous vector.
    //            name            r0 w0 r1 w1  a0     a1     be0  be1  d0             d1             bc0 bc1
    //                            cs we   addr                  be   wd             w0    w1    rv0   rv1   rd
    tbl[0] = mkv("idle",          0, 0, 0, 0, 0,     0,     0,   0,   0,             0,             1, 1,
                                  0, 0, 0,                   0,   0,             1,    1,    0,    0,    0);
    tbl[1] = mkv("p1_wr",         0, 0, 0, 1, 0,     'h10,  0,   'hF, 0,             'hDEADBEEF,    1, 1,
                                  1, 1, 'h10,                'hF, 'hDEADBEEF,    1,    0,    0,    0,    0);
    tbl[2] = mkv("p1_rd",         0, 0, 1, 0, 0,     'h10,  0,   'hF, 0,             0,             1, 1,
                                  1, 0, 'h10,                'hF, 0,             1,    0,    0,    0,    0);
    tbl[3] = mkv("p0_wr",         0, 1, 0, 0, 'h20,  0,     'h3, 0,   'h12345678,    0,             1, 1,
                                  1, 1, 'h20,                'h3, 'h12345678,    0,    1,    0,    1,    'hDEADBEEF);
    tbl[4] = mkv("tie_rd_wr",     1, 0, 0, 1, 'h20,  'h30,  'hF, 'hF, 0,             'h55AA55AA,    1, 1,
                                  1, RR, RR ? 'h30 : 'h20,   'hF, 'h55AA55AA,    RR,   1-RR, 0,    0,    0);
    tbl[5] = mkv("p0_rd_and_wr",  1, 1, 0, 0, 'h40,  0,     'hF, 0,   'h11111111,    0,             1, 1,
                                  1, 0, 'h40,                'hF, 0,             0,    1,    1-RR, 0,    RR ? 0 : 'h5678);
    tbl[6] = mkv("p1_bc0",        0, 0, 1, 0, 0,     'h50,  0,   'hF, 0,             0,             1, 0,
                                  1, 0, 'h50,                'hF, 0,             1,    0,    1,    0,    0);
    tbl[7] = mkv("p0_after_bc0",  1, 0, 0, 0, 'h60,  0,     'hF, 0,   0,             0,             1, 1,
                                  1, 0, 'h60,                'hF, 0,             0,    1,    0,    1,    0);
    tbl[8] = mkv("tie_rd_rd",     1, 0, 1, 0, 'h10,  'h20,  'hF, 'hF, 0,             0,             1, 1,
                                  1, 0, RR ? 'h20 : 'h10,    'hF, 0,             RR,   1-RR, 1,    0,    0);
    tbl[9] = mkv("idle_rv",       0, 0, 0, 0, 0,     0,     0,   0,   0,             0,             1, 1,
                                  0, 0, 0,                   0,   0,             1,    1,    1-RR, RR,   RR ? 'h5678 : 'hDEADBEEF);

    // Reset: RAM quiet, both ports waiting, no readdatavalid.
    reset = 1'b1;
    clr;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_cs", 32'(mem_chipselect), 0);
      chk("rst_we", 32'(mem_write), 0);
      chk("rst_w0", 32'(m0_waitrequest), 1);
      chk("rst_w1", 32'(m1_waitrequest), 1);
      chk("rst_rv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
      tick;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("clken", 32'(mem_clken), 1);
    $display("reset sequence done");

    // Table-driven single-beat vectors.
    for (int i = 0; i < 10; i++) begin
      tick;
      set_req(0, tbl[i].r0[0], tbl[i].w0[0], tbl[i].a0, tbl[i].be0, tbl[i].d0, tbl[i].bc0);
      set_req(1, tbl[i].r1[0], tbl[i].w1[0], tbl[i].a1, tbl[i].be1, tbl[i].d1, tbl[i].bc1);
      @(negedge clk);
      chk({tbl[i].name, "_cs"}, 32'(mem_chipselect), tbl[i].e_cs);
      chk({tbl[i].name, "_we"}, 32'(mem_write), tbl[i].e_we);
      chk({tbl[i].name, "_w0"}, 32'(m0_waitrequest), tbl[i].e_w0);
      chk({tbl[i].name, "_w1"}, 32'(m1_waitrequest), tbl[i].e_w1);
      chk({tbl[i].name, "_rv0"}, 32'(m0_readdatavalid), tbl[i].e_rv0);
      chk({tbl[i].name, "_rv1"}, 32'(m1_readdatavalid), tbl[i].e_rv1);
      if (tbl[i].e_cs != 0) begin
        chk({tbl[i].name, "_addr"}, 32'(mem_address), tbl[i].e_addr);
        chk({tbl[i].name, "_be"}, 32'(mem_byteenable), tbl[i].e_be);
      end
      if (tbl[i].e_we != 0) chk({tbl[i].name, "_wd"}, mem_writedata, tbl[i].e_wd);
      if (tbl[i].e_rv0 != 0) chk({tbl[i].name, "_rd0"}, m0_readdata, tbl[i].e_rd);
      if (tbl[i].e_rv1 != 0) chk({tbl[i].name, "_rd1"}, m1_readdata, tbl[i].e_rd);
      $display("vector %0d %s applied", i, tbl[i].name);
    end
    tick;
    clr;

    // Port 0: 4-beat write burst across the address wrap, stalled after beat 2.
    a_exp[0] = 'h7FFE; a_exp[1] = 'h7FFF; a_exp[2] = 0; a_exp[3] = 'h0000; a_exp[4] = 'h0001;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 2) set_req(0, 0, 0, 'h7FFE, 'hF, 0, 4);
      else set_req(0, 0, 1, 'h7FFE, 'hF, (i < 2) ? i + 1 : i, 4);
      @(negedge clk);
      if (i == 2) begin
        chk("wrap_stall_cs", 32'(mem_chipselect), 0);
        chk("wrap_stall_w0", 32'(m0_waitrequest), 1);
      end else begin
        chk("wrap_w_cs", 32'(mem_chipselect & mem_write), 1);
        chk("wrap_w_addr", 32'(mem_address), a_exp[i]);
        chk("wrap_w_data", mem_writedata, (i < 2) ? i + 1 : i);
        chk("wrap_w_w0", 32'(m0_waitrequest), 0);
      end
    end
    tick;
    clr;
    @(negedge clk);
    chk("wrap_w_done_cs", 32'(mem_chipselect), 0);
    $display("wrap write burst done");

    // Port 0: 4-beat read back across the wrap; data on 4 consecutive cycles.
    tick;
    set_req(0, 1, 0, 'h7FFE, 'hF, 0, 4);
    @(negedge clk);
    chk("wrap_r_addr0", 32'(mem_address), 'h7FFE);
    chk("wrap_r_we", 32'(mem_write), 0);
    chk("wrap_r_w0", 32'(m0_waitrequest), 0);
    r_exp[0] = 'h7FFF; r_exp[1] = 'h0000; r_exp[2] = 'h0001;
    for (int i = 0; i < 4; i++) begin
      tick;
      clr;
      @(negedge clk);
      chk("wrap_r_rv", 32'(m0_readdatavalid), 1);
      chk("wrap_r_data", m0_readdata, i + 1);
      if (i < 3) begin
        chk("wrap_r_cs", 32'(mem_chipselect), 1);
        chk("wrap_r_addr", 32'(mem_address), r_exp[i]);
        chk("wrap_r_w0_held", 32'(m0_waitrequest), 1);
      end else begin
        chk("wrap_r_end_cs", 32'(mem_chipselect), 0);
      end
    end
    tick;
    @(negedge clk);
    chk("wrap_r_rv_end", 32'(m0_readdatavalid), 0);
    $display("wrap read burst done");

    // Byteenable 0x3 over a 0xFFFFFFFF preload.
    write_burst(1, 'h200, 2, 'hFFFFFFFF, 'hF);
    write_burst(1, 'h200, 2, 'h12345678, 'h3);
    read_burst(1, 'h200, 2, 'hFFFF5678);

    // burstcount 0 gives one beat; burstcount 15 is clamped to 8 beats.
    for (int t = 0; t < 2; t++) begin
      cnt_cs = 0;
      cnt_rv = 0;
      tick;
      set_req(1, 1, 0, 'h100, 'hF, 0, (t == 0) ? 0 : 15);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (mem_chipselect) cnt_cs++;
        if (m1_readdatavalid) cnt_rv++;
        tick;
        clr;
      end
      chk((t == 0) ? "bc0_beats" : "bc15_beats", cnt_cs, (t == 0) ? 1 : 8);
      chk((t == 0) ? "bc0_rv" : "bc15_rv", cnt_rv, (t == 0) ? 1 : 8);
      $display("burstcount %0d issued %0d beats", (t == 0) ? 0 : 15, cnt_cs);
    end

    // Reset on beat 3 of an 8-beat read burst.
    tick;
    set_req(0, 1, 0, 'h300, 'hF, 0, 8);
    @(negedge clk);
    chk("rstmid_accept", 32'(m0_waitrequest), 0);
    tick;
    clr;
    @(negedge clk);
    chk("rstmid_beat2_addr", 32'(mem_address), 'h301);
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_cs", 32'(mem_chipselect), 0);
    chk("rstmid_waits", 32'({m0_waitrequest, m1_waitrequest}), 'h3);
    chk("rstmid_rv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    tick;
    reset = 1'b0;
    set_req(1, 1, 0, 'h10, 'hF, 0, 1);
    @(negedge clk);
    chk("post_rst_cs", 32'(mem_chipselect), 1);
    chk("post_rst_addr", 32'(mem_address), 'h10);
    chk("post_rst_w1", 32'(m1_waitrequest), 0);
    chk("post_rst_rv0", 32'(m0_readdatavalid), 0);
    tick;
    clr;
    @(negedge clk);
    chk("post_rst_rv1", 32'(m1_readdatavalid), 1);
    chk("post_rst_rd1", m1_readdata, 'hDEADBEEF);
    chk("post_rst_rv0b", 32'(m0_readdatavalid), 0);
    chk("post_rst_idle_cs", 32'(mem_chipselect), 0);
    $display("reset mid-burst done");

    // Both ports request single reads for 8 cycles. The last grant went to
    // port 1, so the first tie goes to port 0 in either mode.
    prev_g = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      set_req(0, 1, 0, 'h400 + k, 'hF, 0, 1);
      set_req(1, 1, 0, 'h500 + k, 'hF, 0, 1);
      g = (RR != 0) ? (k % 2) : 0;
      @(negedge clk);
      chk("tie_w0", 32'(m0_waitrequest), (g != 0) ? 1 : 0);
      chk("tie_w1", 32'(m1_waitrequest), (g != 1) ? 1 : 0);
      chk("tie_addr", 32'(mem_address), (g != 0) ? 'h500 + k : 'h400 + k);
      if (k > 0) begin
        chk("tie_rv0", 32'(m0_readdatavalid), (prev_g == 0) ? 1 : 0);
        chk("tie_rv1", 32'(m1_readdatavalid), (prev_g == 1) ? 1 : 0);
      end
      $display("tie cycle %0d granted port %0d", k, g);
      prev_g = g;
    end
    tick;
    clr;
    @(negedge clk);
    chk("tie_last_rv0", 32'(m0_readdatavalid), (prev_g == 0) ? 1 : 0);
    chk("tie_last_rv1", 32'(m1_readdatavalid), (prev_g == 1) ? 1 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
